// File: rtl/spi_minion_fifo.sv
// -----------------------------------------------------------------------------
// spi_minion_fifo
//
// SPI minion (slave) for fixed-width packets. The receive and transmit paths
// are each buffered in a DEPTH-entry FIFO. Both FIFOs face the on-chip side as
// val/rdy streams. The minion supports all four SPI modes through CPOL and
// CPHA. It reports the parity of the last received word, plus sticky
// overflow and underflow flags.
//
// Ports
//   clk        system clock
//   reset      synchronous reset, active low
//   cs         SPI chip select, active low (asynchronous to clk)
//   sclk       SPI clock (asynchronous)
//   mosi       SPI data from the master (asynchronous)
//   miso       SPI data to the master (registered)
//   recv_msg   head of the RX FIFO; meaningful only while recv_val=1
//   recv_val   RX FIFO non-empty
//   recv_rdy   consumer pops the RX head when recv_val & recv_rdy
//   send_msg   word to transmit
//   send_val   producer offers send_msg
//   send_rdy   TX FIFO not full
//   parity     XOR of the last word pushed into the RX FIFO
//   overflow   sticky: a received word was dropped because the RX FIFO was full
//   underflow  sticky: a packet started while the TX FIFO was empty
// -----------------------------------------------------------------------------

// Circular-buffer FIFO with first-word-fall-through head output.
// The caller gates push and pop, so push only happens when there is room
// (or when a pop happens in the same cycle), and pop only happens when the
// FIFO is non-empty.
//   push/push_data  write one entry
//   pop             retire the head entry
//   head            current head entry (combinational)
//   empty/full      occupancy status
module spi_minion_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [W-1:0]     mem [DEPTH];

  assign wr_idx = wr_ptr_reg[IDX_W-1:0];
  assign rd_idx = rd_ptr_reg[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_idx == IDX_W'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  assign head  = mem[rd_idx];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end
endmodule

module spi_minion_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         sclk,
  input  logic         mosi,
  output logic         miso,
  output logic [W-1:0] recv_msg,
  output logic         recv_val,
  input  logic         recv_rdy,
  input  logic [W-1:0] send_msg,
  input  logic         send_val,
  output logic         send_rdy,
  output logic         parity,
  output logic         overflow,
  output logic         underflow
);
  localparam int   CNT_W    = $clog2(W);
  localparam logic IDLE_LVL = (CPOL != 0);

  // Two-flop synchronisers, plus one history flop each for edge detection
  logic cs_meta_reg, cs_sync_reg, cs_prev_reg;
  logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
  logic mosi_meta_reg, mosi_sync_reg;

  logic [CNT_W-1:0] bit_cnt_reg;
  logic [W-1:0]     rx_sr_reg;
  // tx_sr_reg holds the bits that have not yet been presented on miso.
  logic [W-1:0]     tx_sr_reg;
  logic             miso_reg;
  logic             parity_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic cs_active, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic last_bit, pkt_start;
  logic [W-1:0] rx_word;
  logic [W-1:0] tx_head, tx_word;
  logic rx_empty, rx_full, rx_pop, rx_push;
  logic tx_empty, tx_full, tx_pop, tx_push;

  assign cs_active  = !cs_sync_reg;
  assign cs_fall    = cs_prev_reg && !cs_sync_reg;
  assign lead_edge  = (sclk_prev_reg == IDLE_LVL) && (sclk_sync_reg != IDLE_LVL);
  assign trail_edge = (sclk_prev_reg != IDLE_LVL) && (sclk_sync_reg == IDLE_LVL);

  assign sample_edge = cs_active && ((CPHA != 0) ? trail_edge : lead_edge);
  assign shift_edge  = cs_active && ((CPHA != 0) ? lead_edge : trail_edge);

  assign last_bit  = sample_edge && (bit_cnt_reg == CNT_W'(W - 1));
  assign rx_word   = {rx_sr_reg[W-2:0], mosi_sync_reg};
  // The wrap on the last sample edge also opens the next packet.
  // If cs rises afterwards, the word popped here is simply lost.
  assign pkt_start = cs_fall || last_bit;

  assign tx_pop  = pkt_start && !tx_empty;
  assign tx_word = tx_empty ? '0 : tx_head;
  assign tx_push = send_val && send_rdy;

  // A push into a full RX FIFO still succeeds when the head leaves in the same cycle.
  assign rx_pop  = recv_val && recv_rdy;
  assign rx_push = last_bit && (!rx_full || rx_pop);

  spi_minion_fifo_buf #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_word),
    .pop       (rx_pop),
    .head      (recv_msg),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  spi_minion_fifo_buf #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (send_msg),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Synchronisers reset to the idle bus state, so that reset itself produces no edges.
      cs_meta_reg   <= 1'b1;
      cs_sync_reg   <= 1'b1;
      cs_prev_reg   <= 1'b1;
      sclk_meta_reg <= IDLE_LVL;
      sclk_sync_reg <= IDLE_LVL;
      sclk_prev_reg <= IDLE_LVL;
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
      bit_cnt_reg   <= '0;
      rx_sr_reg     <= '0;
      tx_sr_reg     <= '0;
      miso_reg      <= 1'b0;
      parity_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      cs_meta_reg   <= cs;
      cs_sync_reg   <= cs_meta_reg;
      cs_prev_reg   <= cs_sync_reg;
      sclk_meta_reg <= sclk;
      sclk_sync_reg <= sclk_meta_reg;
      sclk_prev_reg <= sclk_sync_reg;
      mosi_meta_reg <= mosi;
      mosi_sync_reg <= mosi_meta_reg;

      if (!cs_active) begin
        // Deselected: discard any partial packet and keep miso quiet.
        bit_cnt_reg <= '0;
        rx_sr_reg   <= '0;
        tx_sr_reg   <= '0;
        miso_reg    <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_sr_reg   <= rx_word;
          bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + CNT_W'(1);
        end

        if (cs_fall) begin
          // In CPHA=0 mode, the master samples before any shift edge,
          // so the MSB must already be on miso.
          if (CPHA == 0) begin
            miso_reg  <= tx_word[W-1];
            tx_sr_reg <= tx_word << 1;
          end else begin
            tx_sr_reg <= tx_word;
          end
        end else if (last_bit) begin
          // miso keeps the final bit until the next shift edge.
          // That edge presents the new word's MSB.
          tx_sr_reg <= tx_word;
        end else if (shift_edge) begin
          miso_reg  <= tx_sr_reg[W-1];
          tx_sr_reg <= tx_sr_reg << 1;
        end
      end

      if (pkt_start && tx_empty) underflow_reg <= 1'b1;
      if (last_bit && rx_full && !rx_pop) overflow_reg <= 1'b1;
      if (rx_push) parity_reg <= ^rx_word;
    end
  end

  assign miso      = miso_reg;
  assign recv_val  = !rx_empty;
  assign send_rdy  = !tx_full;
  assign parity    = parity_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
endmodule
